// File: rtl/axi_hp_frame_writer_pkg.sv
// rtl/axi_hp_frame_writer_pkg.sv - shared constants and types for the HP frame writer
package axi_hp_frame_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam logic [2:0] AXSIZE_4B  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ADDR,
    DATA,
    RESP,
    DONE
  } state_e;

endpackage

// File: rtl/axi_hp_frame_writer_if.sv
// rtl/axi_hp_frame_writer_if.sv - capture stream plus AXI4 write channels of the frame writer
interface axi_hp_frame_writer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0]   S_TDATA;
  logic                S_TVALID;
  logic                S_TREADY;
  logic                S_TLAST;
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [7:0]          M_AXI_AWLEN;
  logic [2:0]          M_AXI_AWSIZE;
  logic [1:0]          M_AXI_AWBURST;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WLAST;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;

  modport master (
    input  S_TDATA, S_TVALID, S_TLAST,
    output S_TREADY,
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    output S_TDATA, S_TVALID, S_TLAST,
    input  S_TREADY,
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/axi_hp_sync_fifo.sv
// rtl/axi_hp_sync_fifo.sv - single-clock first-word-fall-through FIFO
module axi_hp_sync_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end
endmodule

// File: rtl/axi_hp_frame_writer.sv
// rtl/axi_hp_frame_writer.sv - buffers one capture frame and writes it to DDR as INCR bursts
module axi_hp_frame_writer
  import axi_hp_frame_pkg::*;
#(
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_BURST_LEN      = 16,
  parameter logic [31:0] C_FRAME_BASE     = 32'h1000_0000,
  parameter int unsigned C_FRAME_WORDS    = 76800,
  parameter int unsigned C_FIFO_DEPTH     = 64
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 INIT_FRAME,
  output logic                 BUSY,
  output logic                 FRAME_DONE,
  output logic                 ERROR,
  axi_hp_frame_writer_if.master bus
);
  localparam int unsigned CNT_W  = $clog2(C_FRAME_WORDS + 1);
  localparam int unsigned FCNT_W = $clog2(C_FIFO_DEPTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] burst_idx_q, burst_idx_d;
  logic [7:0]       awlen_q, awlen_d;
  logic [7:0]       beat_q, beat_d;
  logic             error_q, error_d;

  logic                        fifo_full, fifo_empty, fifo_pop, s_accept;
  logic [FCNT_W-1:0]           fifo_count;
  logic [C_AXI_DATA_WIDTH-1:0] fifo_rdata;
  logic [31:0]                 remaining, blen;

  axi_hp_sync_fifo #(
    .WIDTH (C_AXI_DATA_WIDTH),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (s_accept),
    .wdata_i (bus.S_TDATA),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Only the last burst of a frame can be shorter than C_BURST_LEN.
  assign remaining = C_FRAME_WORDS - 32'(out_cnt_q);
  assign blen      = (remaining < C_BURST_LEN) ? remaining : C_BURST_LEN;

  assign bus.S_TREADY      = BUSY && !fifo_full && (32'(in_cnt_q) < C_FRAME_WORDS);
  assign s_accept          = bus.S_TVALID && bus.S_TREADY;
  assign fifo_pop          = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
  assign ERROR             = error_q;
  assign bus.M_AXI_AWSIZE  = AXSIZE_4B;
  assign bus.M_AXI_AWBURST = BURST_INCR;
  assign bus.M_AXI_WSTRB   = '1;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    burst_idx_d = burst_idx_q;
    awlen_d     = awlen_q;
    beat_d      = beat_q;
    error_d     = error_q;
    BUSY              = 1'b0;
    FRAME_DONE        = 1'b0;
    bus.M_AXI_AWVALID = 1'b0;
    bus.M_AXI_AWADDR  = '0;
    bus.M_AXI_AWLEN   = '0;
    bus.M_AXI_WVALID  = 1'b0;
    bus.M_AXI_WDATA   = '0;
    bus.M_AXI_WLAST   = 1'b0;
    bus.M_AXI_BREADY  = 1'b0;

    // TLAST must mark exactly the final word; a mismatch flags but never reshapes bursts.
    if (s_accept) begin
      in_cnt_d = in_cnt_q + CNT_W'(1);
      if (bus.S_TLAST != (32'(in_cnt_q) == C_FRAME_WORDS - 1)) error_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (INIT_FRAME) begin
          state_d     = FILL;
          error_d     = 1'b0;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          burst_idx_d = '0;
        end
      end
      FILL: begin
        BUSY = 1'b1;
        if (32'(fifo_count) >= blen) begin
          state_d = ADDR;
          awlen_d = 8'(blen - 32'd1);
        end
      end
      ADDR: begin
        BUSY              = 1'b1;
        bus.M_AXI_AWVALID = 1'b1;
        bus.M_AXI_AWLEN   = awlen_q;
        bus.M_AXI_AWADDR  = C_AXI_ADDR_WIDTH'(C_FRAME_BASE)
                          + C_AXI_ADDR_WIDTH'(burst_idx_q) * C_AXI_ADDR_WIDTH'(C_BURST_LEN * 4);
        if (bus.M_AXI_AWREADY) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        BUSY             = 1'b1;
        bus.M_AXI_WVALID = !fifo_empty;
        bus.M_AXI_WDATA  = fifo_rdata;
        bus.M_AXI_WLAST  = (beat_q == awlen_q);
        if (fifo_pop) begin
          out_cnt_d = out_cnt_q + CNT_W'(1);
          beat_d    = beat_q + 8'd1;
          if (beat_q == awlen_q) state_d = RESP;
        end
      end
      RESP: begin
        BUSY             = 1'b1;
        bus.M_AXI_BREADY = 1'b1;
        if (bus.M_AXI_BVALID) begin
          if (bus.M_AXI_BRESP != RESP_OKAY) error_d = 1'b1;
          burst_idx_d = burst_idx_q + CNT_W'(1);
          state_d     = (32'(out_cnt_q) == C_FRAME_WORDS) ? DONE : FILL;
        end
      end
      DONE: begin
        FRAME_DONE = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      burst_idx_q <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      burst_idx_q <= burst_idx_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
      error_q     <= error_d;
    end
  end
endmodule

// File: tb/tb_axi_hp_frame_writer.sv
// tb/tb_axi_hp_frame_writer.sv - randomized self-checking bench for axi_hp_frame_writer
module tb_axi_hp_frame_writer;
  localparam int FW = 40;
  localparam int BL = 16;
  localparam int NB = (FW + BL - 1) / BL;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic INIT_FRAME = 1'b0;
  logic BUSY, FRAME_DONE, ERROR;

  axi_hp_frame_writer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_hp_frame_writer #(
    .C_AXI_ADDR_WIDTH (32),
    .C_AXI_DATA_WIDTH (32),
    .C_BURST_LEN      (BL),
    .C_FRAME_BASE     (BASE),
    .C_FRAME_WORDS    (FW),
    .C_FIFO_DEPTH     (64)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .INIT_FRAME (INIT_FRAME),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .ERROR      (ERROR),
    .bus        (bus)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;

  logic [31:0] words [48];
  int n_words = 0, tl_pos = 0, in_idx = 0;
  bit s_gaps = 0, last_acc = 0;
  int aw_delay = 0, w_mode = 0, err_burst = -1, aw_seen = 0;
  bit b_pending = 0, mon_en = 1, exp_err = 0;
  int aw_k = 0, w_n = 0, b_k = 0, done_cnt = 0;
  int cyc = 0, last_b_cyc = 0, acc16_cyc = 0;
  bit first_aw_seen = 0, aw_stall_prev = 0, w_stall_prev = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k);
    return BASE + 32'(k * BL * 4);
  endfunction

  function automatic int exp_len(input int k);
    return (FW - k * BL < BL) ? FW - k * BL : BL;
  endfunction

  // Slave and stream stimulus are driven just after each rising edge.
  initial begin
    bus.S_TDATA = '0; bus.S_TVALID = 0; bus.S_TLAST = 0;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0;
    bus.M_AXI_BRESP = 2'b00; bus.M_AXI_BVALID = 0;
    forever begin
      @(posedge ACLK); #1;
      bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_seen >= aw_delay);
      case (w_mode)
        0: bus.M_AXI_WREADY = 1'b1;
        1: bus.M_AXI_WREADY = !bus.M_AXI_WREADY;
        default: bus.M_AXI_WREADY = 1'($urandom_range(0, 1));
      endcase
      bus.M_AXI_BVALID = b_pending;
      bus.M_AXI_BRESP = (b_pending && b_k == err_burst) ? 2'b10 : 2'b00;
      if (in_idx < n_words) begin
        if (!(bus.S_TVALID && !last_acc)) bus.S_TVALID = !s_gaps || ($urandom_range(0, 3) != 0);
        bus.S_TDATA = words[in_idx];
        bus.S_TLAST = (in_idx == tl_pos);
      end else begin
        bus.S_TVALID = 1'b0;
        bus.S_TLAST = 1'b0;
      end
    end
  end

  // Reference model: each handshake seen mid-cycle completes at the next rising edge.
  initial forever begin
    @(negedge ACLK);
    cyc++;
    if (mon_en) begin
      if (aw_stall_prev) chk("awvalid_hold", bus.M_AXI_AWVALID, 1);
      if (w_stall_prev) chk("wvalid_hold", bus.M_AXI_WVALID, 1);
      if (bus.M_AXI_WVALID) begin
        if (w_n >= FW) chk("w_extra_beat", w_n, FW - 1);
        else begin
          chk("w_after_aw", (w_n / BL) < aw_k, 1);
          chk("wdata", bus.M_AXI_WDATA, words[w_n]);
          chk("wlast", bus.M_AXI_WLAST, (w_n % BL == BL - 1) || (w_n == FW - 1));
        end
        if (bus.M_AXI_WREADY) begin
          w_n++;
          if (bus.M_AXI_WLAST) b_pending = 1;
        end
      end
      if (bus.M_AXI_AWVALID) begin
        if (!first_aw_seen) begin
          chk("aw_latency", cyc - acc16_cyc, 2);
          first_aw_seen = 1;
        end
        chk("awaddr", bus.M_AXI_AWADDR, exp_addr(aw_k));
        chk("awlen", bus.M_AXI_AWLEN, exp_len(aw_k) - 1);
        if (bus.M_AXI_AWREADY) begin aw_k++; aw_seen = 0; end
        else aw_seen++;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
        b_k++;
        b_pending = 0;
        last_b_cyc = cyc;
      end
      last_acc = 0;
      if (bus.S_TVALID && in_idx >= FW) chk("tready_backpressure", bus.S_TREADY, 0);
      else if (bus.S_TVALID && bus.S_TREADY) begin
        in_idx++;
        last_acc = 1;
        if (in_idx == (FW < BL ? FW : BL)) acc16_cyc = cyc;
      end
      if (FRAME_DONE) begin
        done_cnt++;
        chk("done_after_last_b", cyc - last_b_cyc, 1);
        chk("done_b_count", b_k, NB);
        chk("done_error", ERROR, exp_err);
        chk("done_busy_low", BUSY, 0);
      end
      aw_stall_prev = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
      w_stall_prev = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_busy", BUSY, 0);
    chk("rst_done", FRAME_DONE, 0);
    chk("rst_error", ERROR, 0);
    chk("rst_tready", bus.S_TREADY, 0);
    chk("rst_awvalid", bus.M_AXI_AWVALID, 0);
    chk("rst_awaddr", bus.M_AXI_AWADDR, 0);
    chk("rst_awlen", bus.M_AXI_AWLEN, 0);
    chk("rst_awsize", bus.M_AXI_AWSIZE, 3'b010);
    chk("rst_awburst", bus.M_AXI_AWBURST, 2'b01);
    chk("rst_wvalid", bus.M_AXI_WVALID, 0);
    chk("rst_wdata", bus.M_AXI_WDATA, 0);
    chk("rst_wlast", bus.M_AXI_WLAST, 0);
    chk("rst_wstrb", bus.M_AXI_WSTRB, 4'hF);
    chk("rst_bready", bus.M_AXI_BREADY, 0);
    chk("rst_fifo_empty", dut.u_fifo.count_o, 0);
  endtask

  task automatic start_frame(input int aw_d, input int w_m, input int err_b, input int tl,
                             input int nw, input bit gaps, input bit seq_data);
    aw_delay = aw_d; w_mode = w_m; err_burst = err_b; tl_pos = tl; s_gaps = gaps;
    for (int i = 0; i < 48; i++) words[i] = seq_data ? 32'(i) : $urandom;
    exp_err = (err_b >= 0) || (tl != FW - 1);
    aw_k = 0; w_n = 0; b_k = 0; done_cnt = 0; in_idx = 0;
    first_aw_seen = 0; acc16_cyc = 0;
    @(posedge ACLK); #1;
    n_words = nw;
    INIT_FRAME = 1'b1;
    @(posedge ACLK); #1;
    INIT_FRAME = 1'b0;
    chk("busy_after_init", BUSY, 1);
    chk("error_cleared_by_init", ERROR, 0);
  endtask

  task automatic finish_frame();
    for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge ACLK);
    chk("frame_done_seen", done_cnt, 1);
    repeat (4) @(negedge ACLK);
    chk("done_exactly_once", done_cnt, 1);
    chk("aw_count", aw_k, NB);
    chk("w_beats", w_n, FW);
    chk("b_count", b_k, NB);
    chk("words_accepted", in_idx, FW);
    chk("error_sticky", ERROR, exp_err);
    chk("idle_busy", BUSY, 0);
    n_words = 0;
  endtask

  initial begin
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    chk_reset_outputs();

    start_frame(0, 0, -1, FW - 1, FW, 0, 1);
    finish_frame();

    start_frame(5, 1, -1, FW - 1, FW, 1, 0);
    finish_frame();

    start_frame(0, 2, NB - 1, FW - 1, FW, 1, 0);
    finish_frame();

    start_frame(1, 2, -1, FW - 1, FW, 1, 0);
    finish_frame();

    start_frame(2, 2, -1, 20, FW + 1, 0, 0);
    finish_frame();

    start_frame(0, 0, -1, FW - 1, FW, 0, 0);
    begin
      int c;
      for (c = 0; c < 500 && !(aw_k == 2 && bus.M_AXI_WVALID); c++) @(negedge ACLK);
      chk("reached_second_burst_data", c < 500, 1);
    end
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    mon_en = 0;
    n_words = 0;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    b_pending = 0; aw_seen = 0; aw_stall_prev = 0; w_stall_prev = 0;
    chk_reset_outputs();
    repeat (2) @(posedge ACLK);
    mon_en = 1;
    start_frame(0, 2, -1, FW - 1, FW, 1, 0);
    finish_frame();

    start_frame(3, 2, -1, FW - 1, FW, 1, 0);
    begin
      int c;
      for (c = 0; c < 500 && aw_k < 1; c++) @(negedge ACLK);
      chk("busy_before_reinit", BUSY, 1);
    end
    @(posedge ACLK); #1;
    INIT_FRAME = 1'b1;
    @(posedge ACLK); #1;
    INIT_FRAME = 1'b0;
    finish_frame();

    for (int f = 0; f < 3; f++) begin
      start_frame($urandom_range(0, 3), 2, -1, FW - 1, FW, 1, 0);
      finish_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_hp_frame_writer.md
Name: axi_hp_frame_writer

Overview:
- Upstream feeder of the axi_hp AXI4 master path (HP port into DDR).
- Accepts a 32-bit pixel/word stream from the capture pipeline and buffers it in a small FIFO.
- Writes exactly one frame to a fixed DDR frame buffer as INCR write bursts: one burst outstanding, sequential addresses from the base.
- Control follows the axi_hp init/done/error convention: start pulse, one-cycle done pulse, sticky error.

Parameters:
- C_AXI_ADDR_WIDTH, 32, AXI address width.
- C_AXI_DATA_WIDTH, 32, AXI and stream data width. Only 32 is supported.
- C_BURST_LEN, 16, beats per full burst. Power of two, 2..256.
- C_FRAME_BASE, 32'h1000_0000, frame buffer byte address. Must be aligned to C_BURST_LEN*4.
- C_FRAME_WORDS, 76800, 32-bit words per frame. Must be ≥1.
- C_FIFO_DEPTH, 64, input FIFO entries. Power of two, ≥ C_BURST_LEN.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  synchronous, active-high reset.
- INIT_FRAME  in  1  one-cycle pulse: start a frame. Ignored unless the block is idle.
- BUSY  out  1  high from INIT_FRAME acceptance until FRAME_DONE.
- FRAME_DONE  out  1  one-cycle pulse after the final B response.
- ERROR  out  1  sticky error flag; cleared by the next accepted INIT_FRAME or by reset.
- S_TDATA  in  32  stream data.
- S_TVALID  in  1  stream valid.
- S_TREADY  out  1  stream ready.
- S_TLAST  in  1  marks the last word of the frame.
- M_AXI_AWADDR  out  C_AXI_ADDR_WIDTH  burst start address.
- M_AXI_AWLEN  out  8  beats minus 1.
- M_AXI_AWSIZE  out  3  fixed 3'b010.
- M_AXI_AWBURST  out  2  fixed 2'b01 (INCR).
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4  fixed 4'hF.
- M_AXI_WLAST  out  1
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1

Behaviour:
- Reset: all outputs are 0 except the constant AWSIZE/AWBURST/WSTRB. FIFO is flushed, counters cleared, state = IDLE.
- Reset mid-frame: the same reset values apply on the next edge. Abandoning an open AXI transaction is acceptable because reset is system-wide.
- Stream input:
  - S_TREADY = BUSY && !fifo_full && (in_cnt < C_FRAME_WORDS).
  - A word is accepted on S_TVALID && S_TREADY; in_cnt increments.
  - Words beyond C_FRAME_WORDS are back-pressured and never accepted.
- TLAST check:
  - S_TLAST accepted with in_cnt != C_FRAME_WORDS-1 sets ERROR.
  - Last word accepted without S_TLAST sets ERROR.
  - Addressing and burst lengths are unaffected.
- Burst length: blen = min(C_BURST_LEN, C_FRAME_WORDS - out_cnt). Only the final burst can be short.
- Address: AWADDR = C_FRAME_BASE + burst_idx*C_BURST_LEN*4. The alignment rule on C_FRAME_BASE guarantees no 4 KB crossing.
- FSM states:
  - IDLE: on INIT_FRAME → FILL. Clear ERROR, in_cnt, out_cnt and burst_idx; BUSY=1 from the next cycle.
  - FILL: when fifo_count ≥ blen → ADDR. A burst is never started without all its data buffered.
  - ADDR: AWVALID=1 with AWADDR/AWLEN held stable until AWREADY. On handshake → DATA.
  - DATA:
    - WVALID = 1 (data is guaranteed present); WDATA comes from the FIFO head.
    - Pop on WVALID && WREADY; out_cnt increments.
    - WLAST=1 on beat blen-1. After the WLAST handshake → RESP.
    - WVALID must not drop while WREADY is low.
  - RESP: BREADY=1. On BVALID:
    - BRESP != 2'b00 sets ERROR.
    - burst_idx increments.
    - If out_cnt == C_FRAME_WORDS → DONE, else → FILL.
  - DONE: FRAME_DONE=1 for one cycle; BUSY drops in the same cycle → IDLE.
- No AW/W overlap: W starts only after the AW handshake.
- INIT_FRAME while BUSY is ignored.
- Simultaneous FIFO push and pop is supported; count is unchanged.
- Counter widths are sized by $clog2(C_FRAME_WORDS+1).
- Latency: the first AWVALID appears 1 cycle after the FIFO reaches C_BURST_LEN (or C_FRAME_WORDS, if smaller).

Decomposition:
- Package axi_hp_frame_pkg holds:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - AXSIZE_4B, BURST_INCR.
  - FSM state enum {IDLE, FILL, ADDR, DATA, RESP, DONE}.
- One sub-module: axi_hp_sync_fifo.
  - Parameterized width and depth, synchronous active-high reset.
  - Provides push/pop/full/empty/count outputs, with first-word fall-through.

Test Plan:
- Defaults except C_FRAME_WORDS=40, slave always ready, words 0..39, TLAST on word 39 → three bursts:
  - AWADDR 0x1000_0000 / 0x1000_0040 / 0x1000_0080 with AWLEN 15/15/7.
  - WDATA in order 0..39.
  - FRAME_DONE one cycle after the third B; ERROR=0.
- Slave AWREADY delayed 5 cycles and WREADY toggling 1/0 → AWADDR/AWLEN/WDATA stay stable under stall; beat count and ordering are unchanged; FRAME_DONE asserts once.
- Third B returns BRESP=2'b10 → ERROR=1 and FRAME_DONE still pulses. Next INIT_FRAME clears ERROR; a clean frame follows.
- TLAST on word 20 of 40 → ERROR=1. All 40 words are written at the correct addresses; word 40+ is back-pressured (S_TREADY=0).
- ARESET for 1 cycle during the second burst's DATA state → all outputs return to reset values next cycle and the FIFO is empty. A new INIT_FRAME restarts at 0x1000_0000.
- INIT_FRAME pulsed while BUSY → ignored: no counter reset, and exactly one FRAME_DONE.
